// File: rtl/bl_ant_buf_if.sv
// Signal bundle between bl_order_gen / the sample source and bl_ant_buf.
// Both sides are free-running: there is no ready, and err is the only overrun indication.
interface bl_ant_buf_if #(
   parameter int N_ANTS     = 8,
   parameter int DATA_WIDTH = 16,
   parameter int ANT_BITS   = $clog2(N_ANTS)
);
   logic [DATA_WIDTH-1:0] din;
   logic                  din_valid;
   logic                  din_sync;
   logic                  wr_bank;
   logic [ANT_BITS-1:0]   ant_a;
   logic [ANT_BITS-1:0]   ant_b;
   logic                  buf_sel;
   logic                  rd_en;
   logic                  sync_in;
   logic [DATA_WIDTH-1:0] dout_a;
   logic [DATA_WIDTH-1:0] dout_b;
   logic                  dout_valid;
   logic                  sync_out;
   logic                  err;

   modport slave (
      input  din, din_valid, din_sync, ant_a, ant_b, buf_sel, rd_en, sync_in,
      output wr_bank, dout_a, dout_b, dout_valid, sync_out, err
   );

   modport master (
      output din, din_valid, din_sync, ant_a, ant_b, buf_sel, rd_en, sync_in,
      input  wr_bank, dout_a, dout_b, dout_valid, sync_out, err
   );
endinterface

// File: rtl/bl_ant_buf.sv
// Double-buffered antenna sample store: one bank fills while the correlator reads
// antenna pairs from the other through a fixed two-cycle read pipeline.
module bl_ant_buf #(
   parameter int N_ANTS     = 8,
   parameter int DATA_WIDTH = 16,
   parameter int ANT_BITS   = $clog2(N_ANTS)
) (
   input  logic         clk,
   input  logic         rst,
   bl_ant_buf_if.slave  bus
);
   localparam int DEPTH = 2 * N_ANTS;
   localparam logic [ANT_BITS-1:0] LAST_IDX = ANT_BITS'(N_ANTS - 1);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic [ANT_BITS-1:0] wa_q, wa_d;
   logic                wr_bank_q, wr_bank_d;
   logic [ANT_BITS-1:0] wr_idx;
   logic                err_q, err_d;

   logic                s1_bank_q;
   logic [ANT_BITS-1:0] s1_a_q, s1_b_q;
   logic                s1_vld_q, s1_sync_q;

   logic [DATA_WIDTH-1:0] dout_a_q, dout_a_d;
   logic [DATA_WIDTH-1:0] dout_b_q, dout_b_d;
   logic                  dout_vld_q, sync_out_q;

   // A sync always restarts the block at index 0 of the current bank; only a
   // write landing on the last index flips the bank.
   always_comb begin
      wr_idx    = bus.din_sync ? '0 : wa_q;
      wa_d      = wa_q;
      wr_bank_d = wr_bank_q;
      err_d     = err_q;
      if (bus.din_valid) begin
         if (wr_idx == LAST_IDX) begin
            wa_d      = '0;
            wr_bank_d = ~wr_bank_q;
         end else begin
            wa_d = wr_idx + ANT_BITS'(1);
         end
         if (bus.rd_en && (bus.buf_sel == wr_bank_q)) begin
            err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wa_q      <= '0;
         wr_bank_q <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         wa_q      <= wa_d;
         wr_bank_q <= wr_bank_d;
         err_q     <= err_d;
      end
   end

   // Storage is deliberately not reset.
   always_ff @(posedge clk) begin
      if (!rst && bus.din_valid) begin
         mem_q[{wr_bank_q, wr_idx}] <= bus.din;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_bank_q <= 1'b0;
         s1_a_q    <= '0;
         s1_b_q    <= '0;
         s1_vld_q  <= 1'b0;
         s1_sync_q <= 1'b0;
      end else begin
         s1_bank_q <= bus.buf_sel;
         s1_a_q    <= bus.ant_a;
         s1_b_q    <= bus.ant_b;
         s1_vld_q  <= bus.rd_en;
         s1_sync_q <= bus.sync_in;
      end
   end

   // Memory is read in stage 2 every cycle; outputs only update on a valid read
   // so they hold the last fetched pair between bursts.
   always_comb begin
      dout_a_d = dout_a_q;
      dout_b_d = dout_b_q;
      if (s1_vld_q) begin
         dout_a_d = mem_q[{s1_bank_q, s1_a_q}];
         dout_b_d = mem_q[{s1_bank_q, s1_b_q}];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dout_a_q   <= '0;
         dout_b_q   <= '0;
         dout_vld_q <= 1'b0;
         sync_out_q <= 1'b0;
      end else begin
         dout_a_q   <= dout_a_d;
         dout_b_q   <= dout_b_d;
         dout_vld_q <= s1_vld_q;
         sync_out_q <= s1_sync_q;
      end
   end

   assign bus.wr_bank    = wr_bank_q;
   assign bus.err        = err_q;
   assign bus.dout_a     = dout_a_q;
   assign bus.dout_b     = dout_b_q;
   assign bus.dout_valid = dout_vld_q;
   assign bus.sync_out   = sync_out_q;
endmodule

// File: doc/bl_ant_buf.md
Name: bl_ant_buf

Overview:
- Double-buffered antenna sample store sitting directly downstream of bl_order_gen in the X-engine.
- Write side captures one sample per antenna per block (N_ANTS consecutive samples) into the bank selected by an internal write-bank pointer.
- Read side uses ant_a/ant_b/buf_sel from bl_order_gen to fetch the antenna pair for each baseline and presents them, aligned with valid/sync, to the correlator multiplier stage.

Parameters:
- N_ANTS, 8, antennas per block; power of two, ≥2.
- ANT_BITS, log2(N_ANTS), antenna index width (derived via math_func log2).
- DATA_WIDTH, 16, sample width (complex packed re/im, treated as opaque bits).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- din  in  DATA_WIDTH  antenna sample, write side.
- din_valid  in  1  din is valid this cycle.
- din_sync  in  1  qualifies din as antenna 0 of a new block; only honoured with din_valid.
- wr_bank  out  1  bank currently being written.
- ant_a  in  ANT_BITS  first antenna index from bl_order_gen.
- ant_b  in  ANT_BITS  second antenna index from bl_order_gen.
- buf_sel  in  1  bank to read, from bl_order_gen.
- rd_en  in  1  read request (bl_order_gen en).
- sync_in  in  1  sync pulse travelling with the read stream.
- dout_a  out  DATA_WIDTH  sample of ant_a.
- dout_b  out  DATA_WIDTH  sample of ant_b.
- dout_valid  out  1  dout_a/dout_b valid.
- sync_out  out  1  sync_in delayed to match dout.
- err  out  1  sticky collision flag.

Behaviour:
- Storage: 2 banks × N_ANTS words; bank address = {bank, index}. Memory contents are not reset. Implementation is two read ports (duplicated RAM or register file); any form is acceptable provided latency is exact.
- Write address wa (ANT_BITS bits) and wr_bank reset to 0.
- On din_valid with din_sync=1: write din to [wr_bank][0]; wa←1.
- On din_valid with din_sync=0: write din to [wr_bank][wa]; wa←wa+1.
- When a write lands at index N_ANTS-1 (with or without sync): wa wraps to 0 and wr_bank toggles on the next cycle.
- din_sync arriving mid-block: the partial block is abandoned, there is no bank toggle, and writing restarts at index 0 of the same bank.
- din_valid=0: no write, no state change.
- Read pipeline has fixed 2-cycle latency:
  - Stage 1 registers {buf_sel, ant_a, ant_b, rd_en, sync_in}.
  - Stage 2 registers the memory data.
  - Request at cycle t → dout_a/dout_b/dout_valid/sync_out at t+2.
- Reads are issued every cycle regardless of rd_en. dout_valid = rd_en delayed 2. sync_out = sync_in delayed 2, independent of rd_en.
- dout_a/dout_b hold the last fetched data whenever dout_valid=0; they are zero only after reset.
- ant_a == ant_b (autocorrelation): both outputs carry the same word.
- Same-cycle write and read of the same address: the read returns the pre-write (old) value.
- Collision: err←1 when din_valid=1, rd_en=1 and buf_sel==wr_bank in the same cycle.
  - The write is still performed.
  - err stays set until rst.
- Reset values:
  - dout_a=0, dout_b=0, dout_valid=0, sync_out=0, err=0.
  - wr_bank=0, wa=0.
  - Pipeline valid/sync stages cleared.
- Reset mid-operation: any in-flight read is dropped (no dout_valid from pre-reset requests); any partial write block is discarded.
- No backpressure: upstream guarantees the write rate; err is the only overrun indication.

Test Plan:
- Reset then 8 valid writes 0x0000..0x0007 with din_sync on the first → wr_bank goes 0→1 the cycle after the 8th write; wa=0.
- After the previous fill, drive buf_sel=0, rd_en=1, ant_a=3, ant_b=5 at cycle t → at t+2 dout_a=0x0003, dout_b=0x0005, dout_valid=1. sync_in at t → sync_out=1 at t+2 only.
- Run the bl_order_gen N_ANTS=8 sequence against bank 0 while filling bank 1 with 0x0100+i → every output pair equals {ant_a, ant_b} of the request two cycles earlier; err stays 0.
- Write 3 samples, then din_sync with din=0xAAAA, then 7 more samples → no toggle after the 3 samples. Index 0 of bank 0 holds 0xAAAA. Toggle occurs after the final sample only.
- din_valid=1, rd_en=1, buf_sel=wr_bank=0 in one cycle → err=1 the next cycle and remains 1 through further clean traffic until rst.
- Assert rst for one cycle while dout_valid requests are in flight → dout_valid=0 on the two following cycles. All outputs are 0. The next 8-sample fill lands in bank 0.
